freq_sample_buffer: RTL

Parametrised successor to the frequency-counter sample buffer. It captures `current_freq` on each rising edge of the device-under-test waveform and holds the last DEPTH samples in a circular buffer. It maintains a running sum and a power-of-two moving average, and raises `done_flag` after a programmed number of samples. It sits between the period/frequency measurement core and the result/readout logic on the Cyclone IV counter.

---
 rtl/freq_sample_buffer_if.sv | 30 +++
 rtl/freq_sample_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/freq_sample_buffer_if.sv
// rtl/freq_sample_buffer_if.sv - control, sample and result signals of the frequency sample buffer
interface freq_sample_buffer_if #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
);
  localparam int LOG2_DEPTH = $clog2(DEPTH);

  logic                        enable;
  logic                        in_wave;
  logic [WIDTH-1:0]            current_freq;
  logic [15:0]                 samples_required;
  logic [WIDTH-1:0]            average;
  logic                        average_valid;
  logic [DEPTH*WIDTH-1:0]      buff;
  logic [LOG2_DEPTH-1:0]       wr_ptr;
  logic [15:0]                 sample_count;
  logic                        done_flag;
  logic [WIDTH-1:0]            min_freq;
  logic [WIDTH-1:0]            max_freq;

  modport master (
    output enable, in_wave, current_freq, samples_required,
    input  average, average_valid, buff, wr_ptr, sample_count, done_flag, min_freq, max_freq
  );

  modport slave (
    input  enable, in_wave, current_freq, samples_required,
    output average, average_valid, buff, wr_ptr, sample_count, done_flag, min_freq, max_freq
  );
endinterface

// File: rtl/freq_sample_buffer.sv
// rtl/freq_sample_buffer.sv - circular sample buffer with moving average; FREQ_BUF_MINMAX_EN adds min/max tracking
module freq_sample_buffer #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic                  Clock,
  input  logic                  nReset,
  freq_sample_buffer_if.slave   bus
);
  localparam int LOG2_DEPTH = $clog2(DEPTH);
  localparam int SUM_W      = WIDTH + LOG2_DEPTH;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q, dly_q;
  logic                   strobe, start, capture;
  logic [WIDTH-1:0]       buff_q [DEPTH];
  logic [WIDTH-1:0]       buff_d [DEPTH];
  logic [LOG2_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            target_q, target_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [WIDTH-1:0]       avg_q, avg_d;
  logic                   avg_valid_q, avg_valid_d;
  logic                   done_q, done_d;
  logic [DEPTH*WIDTH-1:0] buff_flat;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= bus.in_wave;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign strobe  = sync2_q & ~dly_q;
  assign start   = (state_q == IDLE) && bus.enable;
  // Dropping enable wins over a coincident strobe
  assign capture = (state_q == COLLECT) && bus.enable && strobe;

  always_comb begin
    state_d     = state_q;
    buff_d      = buff_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    target_d    = target_q;
    sum_d       = sum_q;
    done_d      = done_q;
    avg_d       = WIDTH'(sum_q >> LOG2_DEPTH);
    avg_valid_d = avg_valid_q | (count_q >= 16'(DEPTH));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = COLLECT;
          target_d    = bus.samples_required;
          for (int i = 0; i < DEPTH; i++) buff_d[i] = '0;
          wr_ptr_d    = '0;
          count_d     = '0;
          sum_d       = '0;
          avg_d       = '0;
          avg_valid_d = 1'b0;
          done_d      = 1'b0;
        end
      end
      COLLECT: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (capture) begin
          buff_d[wr_ptr_q] = bus.current_freq;
          wr_ptr_d         = wr_ptr_q + LOG2_DEPTH'(1);
          sum_d            = sum_q + SUM_W'(bus.current_freq) - SUM_W'(buff_q[wr_ptr_q]);
          count_d          = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          if ((target_q != 16'd0) && (count_d == target_q)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!bus.enable) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) buff_q[i] <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      target_q    <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < DEPTH; i++) buff_q[i] <= buff_d[i];
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      target_q    <= target_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    buff_flat = '0;
    for (int i = 0; i < DEPTH; i++) buff_flat[i*WIDTH +: WIDTH] = buff_q[i];
  end

`ifdef FREQ_BUF_MINMAX_EN
  logic             cap_q;
  logic [WIDTH-1:0] cap_data_q, min_q, max_q;

  // Extremes follow the captured sample one cycle later, like the average
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      cap_q      <= 1'b0;
      cap_data_q <= '0;
      min_q      <= '0;
      max_q      <= '0;
    end else if (start) begin
      cap_q      <= 1'b0;
      min_q      <= '1;
      max_q      <= '0;
    end else begin
      cap_q <= capture;
      if (capture) cap_data_q <= bus.current_freq;
      if (cap_q) begin
        if (cap_data_q < min_q) min_q <= cap_data_q;
        if (cap_data_q > max_q) max_q <= cap_data_q;
      end
    end
  end

  assign bus.min_freq = min_q;
  assign bus.max_freq = max_q;
`else
  assign bus.min_freq = '0;
  assign bus.max_freq = '0;
`endif

  assign bus.buff          = buff_flat;
  assign bus.wr_ptr        = wr_ptr_q;
  assign bus.sample_count  = count_q;
  assign bus.average       = avg_q;
  assign bus.average_valid = avg_valid_q;
  assign bus.done_flag     = done_q;
endmodule
